float_multiplier: RTL and testbench

Multi-cycle IEEE-754 single-precision multiplier for the filter datapath. It sits directly upstream of `float_adder`: it forms coefficient × sample products, and each `o_Z`/`o_Z_STB`/`i_Z_ACK` triple connects straight to the adder's `i_A`/`i_AB_STB`/`o_AB_ACK`. It accepts one operand pair per transaction and returns one rounded product, with a strobe/ack handshake on both sides.

---
 rtl/float_multiplier.sv | 219 +++++++++++++++++++++
 tb/tb_float_multiplier.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_multiplier.sv
// float_multiplier: multi-cycle binary32 multiplier, strobe/ack on both sides.
// Define FLOAT_MULTIPLIER_DENORMAL_EN for subnormal support; default is flush-to-zero.

module float_multiplier (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  input  logic        i_AB_STB,
  output logic        o_AB_ACK,
  output logic [31:0] o_Z,
  output logic        o_Z_STB,
  input  logic        i_Z_ACK
);

  typedef enum logic [3:0] {
    GET_INPUT, UNPACK, SPECIAL, NORM_A,
    NORM_B, MUL_0, MUL_1, NORM_1,
    NORM_2, ROUND, PACK, PUT_Z
  } state_t;

  state_t r_state, w_next;

  logic [31:0]       r_a, r_b, r_z, r_o_z;
  logic [23:0]       r_a_m, r_b_m, r_z_m;
  logic signed [9:0] r_a_e, r_b_e, r_z_e;
  logic              r_z_s, r_g, r_r, r_st;
  logic              r_ab_ack, r_z_stb;
  logic [49:0]       r_prod;
  logic [47:0]       w_mul;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic              w_a_zero, w_b_zero;
  logic              w_special, w_z_under;
  logic [31:0]       w_spec_z, w_pack;
  logic [7:0]        w_exp8;

  assign o_AB_ACK = r_ab_ack;
  assign o_Z_STB  = r_z_stb;
  assign o_Z      = r_o_z;

  assign w_a_nan = (r_a_e == 10'sd128) && (r_a_m != 24'd0);
  assign w_b_nan = (r_b_e == 10'sd128) && (r_b_m != 24'd0);
  assign w_a_inf = (r_a_e == 10'sd128) && (r_a_m == 24'd0);
  assign w_b_inf = (r_b_e == 10'sd128) && (r_b_m == 24'd0);
`ifdef FLOAT_MULTIPLIER_DENORMAL_EN
  assign w_a_zero = (r_a_e == -10'sd127) && (r_a_m == 24'd0);
  assign w_b_zero = (r_b_e == -10'sd127) && (r_b_m == 24'd0);
`else
  assign w_a_zero = (r_a_e == -10'sd127);
  assign w_b_zero = (r_b_e == -10'sd127);
`endif

  assign w_mul     = {24'd0, r_a_m} * {24'd0, r_b_m};
  assign w_z_under = (r_z_e < -10'sd126);
  assign w_exp8    = r_z_e[7:0] + 8'd127;

  // first match wins: NaN, inf*0, inf, zero
  always_comb begin
    w_special = 1'b1;
    w_spec_z  = {r_z_s, 31'd0};
    if (w_a_nan || w_b_nan) begin
      w_spec_z = 32'h7FC0_0000;
    end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_spec_z = 32'h7FC0_0000;
    end else if (w_a_inf || w_b_inf) begin
      w_spec_z = {r_z_s, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_zero) begin
      w_spec_z = {r_z_s, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  always_comb begin
    w_pack = {r_z_s, w_exp8, r_z_m[22:0]};
    if (r_z_e > 10'sd127) begin
      w_pack = {r_z_s, 8'hFF, 23'd0};
    end else if ((r_z_e == -10'sd126) && !r_z_m[23]) begin
      w_pack = {r_z_s, 8'd0, r_z_m[22:0]};
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) r_state <= GET_INPUT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      GET_INPUT: if (r_ab_ack && i_AB_STB) w_next = UNPACK;
      UNPACK:    w_next = SPECIAL;
      SPECIAL:   w_next = w_special ? PUT_Z : NORM_A;
`ifdef FLOAT_MULTIPLIER_DENORMAL_EN
      NORM_A:    if (r_a_m[23]) w_next = NORM_B;
      NORM_B:    if (r_b_m[23]) w_next = MUL_0;
      NORM_2:    if (!w_z_under) w_next = ROUND;
`else
      NORM_A:    w_next = NORM_B;
      NORM_B:    w_next = MUL_0;
      NORM_2:    w_next = w_z_under ? PUT_Z : ROUND;
`endif
      MUL_0:     w_next = MUL_1;
      MUL_1:     w_next = NORM_1;
      NORM_1:    if (r_z_m[23]) w_next = NORM_2;
      ROUND:     w_next = PACK;
      PACK:      w_next = PUT_Z;
      PUT_Z:     if (r_z_stb && i_Z_ACK) w_next = GET_INPUT;
      default:   w_next = GET_INPUT;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_ab_ack <= 1'b0;
      r_z_stb  <= 1'b0;
      r_o_z    <= 32'd0;
    end else begin
      unique case (r_state)
        GET_INPUT: begin
          r_ab_ack <= 1'b1;
          if (r_ab_ack && i_AB_STB) begin
            r_a      <= i_A;
            r_b      <= i_B;
            r_ab_ack <= 1'b0;
          end
        end
        UNPACK: begin
          r_a_m <= {1'b0, r_a[22:0]};
          r_b_m <= {1'b0, r_b[22:0]};
          r_a_e <= $signed({2'b00, r_a[30:23]}) - 10'sd127;
          r_b_e <= $signed({2'b00, r_b[30:23]}) - 10'sd127;
          r_z_s <= r_a[31] ^ r_b[31];
        end
        SPECIAL: begin
          if (w_special) begin
            r_z <= w_spec_z;
          end else begin
            if (r_a_e == -10'sd127) r_a_e <= -10'sd126;
            else                    r_a_m[23] <= 1'b1;
            if (r_b_e == -10'sd127) r_b_e <= -10'sd126;
            else                    r_b_m[23] <= 1'b1;
          end
        end
`ifdef FLOAT_MULTIPLIER_DENORMAL_EN
        NORM_A: begin
          if (!r_a_m[23]) begin
            r_a_m <= r_a_m << 1;
            r_a_e <= r_a_e - 10'sd1;
          end
        end
        NORM_B: begin
          if (!r_b_m[23]) begin
            r_b_m <= r_b_m << 1;
            r_b_e <= r_b_e - 10'sd1;
          end
        end
        NORM_2: begin
          if (w_z_under) begin
            r_z_m <= r_z_m >> 1;
            r_g   <= r_z_m[0];
            r_r   <= r_g;
            r_st  <= r_st | r_r;
            r_z_e <= r_z_e + 10'sd1;
          end
        end
`else
        NORM_A: begin
        end
        NORM_B: begin
        end
        NORM_2: begin
          if (w_z_under) r_z <= {r_z_s, 31'd0};
        end
`endif
        MUL_0: begin
          r_prod <= {w_mul, 2'b00};
          r_z_e  <= r_a_e + r_b_e + 10'sd1;
        end
        MUL_1: begin
          r_z_m <= r_prod[49:26];
          r_g   <= r_prod[25];
          r_r   <= r_prod[24];
          r_st  <= |r_prod[23:0];
        end
        NORM_1: begin
          if (!r_z_m[23]) begin
            r_z_m <= {r_z_m[22:0], r_g};
            r_g   <= r_r;
            r_r   <= 1'b0;
            r_z_e <= r_z_e - 10'sd1;
          end
        end
        ROUND: begin
          if (r_g && (r_r || r_st || r_z_m[0])) begin
            r_z_m <= r_z_m + 24'd1;
            if (r_z_m == 24'hFF_FFFF) r_z_e <= r_z_e + 10'sd1;
          end
        end
        PACK: begin
          r_z <= w_pack;
        end
        PUT_Z: begin
          r_z_stb <= 1'b1;
          if (!r_z_stb) r_o_z <= r_z;
          if (r_z_stb && i_Z_ACK) begin
            r_z_stb  <= 1'b0;
            r_ab_ack <= 1'b1;
          end
        end
        default: begin
          r_ab_ack <= 1'b0;
          r_z_stb  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_multiplier.sv
// tb_float_multiplier: random and directed checks of float_multiplier
// against an exact-arithmetic IEEE binary32 product model.

module tb_float_multiplier;

  logic        i_CLK = 1'b0;
  logic        i_RST = 1'b1;
  logic [31:0] i_A = '0;
  logic [31:0] i_B = '0;
  logic        i_AB_STB = 1'b0;
  logic        o_AB_ACK;
  logic [31:0] o_Z;
  logic        o_Z_STB;
  logic        i_Z_ACK = 1'b0;

  int checks = 0;
  int errors = 0;

  float_multiplier dut (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .i_A(i_A), .i_B(i_B),
    .i_AB_STB(i_AB_STB), .o_AB_ACK(o_AB_ACK),
    .o_Z(o_Z), .o_Z_STB(o_Z_STB),
    .i_Z_ACK(i_Z_ACK)
  );

  always #5 i_CLK = ~i_CLK;

  always @(negedge i_CLK) begin
    if (!i_RST) begin
      checks++;
      if (o_AB_ACK === 1'b1 && o_Z_STB === 1'b1) begin
        errors++;
        $display("FAIL excl: o_AB_ACK and o_Z_STB both 1 at %0t", $time);
      end
    end
  end

  // Exact product of the two operands, rounded to nearest-even.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] z, output int lat);
    logic s, an, bn, ai, bi, az, bz, g, st;
    logic [7:0] xa, xb;
    logic [63:0] ma, mb, p, pn, mant;
    int ea, eb, e, k, sh, lza, lzb, s1, n2;
    s  = a[31] ^ b[31];
    xa = a[30:23];
    xb = b[30:23];
    an = (xa == 8'hFF) && (a[22:0] != 0);
    bn = (xb == 8'hFF) && (b[22:0] != 0);
    ai = (xa == 8'hFF) && (a[22:0] == 0);
    bi = (xb == 8'hFF) && (b[22:0] == 0);
`ifdef FLOAT_MULTIPLIER_DENORMAL_EN
    az = (xa == 8'd0) && (a[22:0] == 0);
    bz = (xb == 8'd0) && (b[22:0] == 0);
`else
    az = (xa == 8'd0);
    bz = (xb == 8'd0);
`endif
    lat = 3;
    z = {s, 31'd0};
    if (an || bn) begin
      z = 32'h7FC0_0000;
    end else if ((ai && bz) || (bi && az)) begin
      z = 32'h7FC0_0000;
    end else if (ai || bi) begin
      z = {s, 8'hFF, 23'd0};
    end else if (az || bz) begin
      z = {s, 31'd0};
    end else begin
      ma = (xa == 0) ? {41'd0, a[22:0]} : {40'd0, 1'b1, a[22:0]};
      mb = (xb == 0) ? {41'd0, b[22:0]} : {40'd0, 1'b1, b[22:0]};
      ea = (xa == 0) ? -126 : int'(xa) - 127;
      eb = (xb == 0) ? -126 : int'(xb) - 127;
      lza = 0;
      while (lza < 23 && ma[23-lza] == 1'b0) lza++;
      lzb = 0;
      while (lzb < 23 && mb[23-lzb] == 1'b0) lzb++;
      pn = (ma << lza) * (mb << lzb);
      s1 = pn[47] ? 0 : 1;
      p = ma * mb;
      k = 47;
      while (k > 0 && p[k] == 1'b0) k--;
      e = ea + eb - 46 + k;
`ifndef FLOAT_MULTIPLIER_DENORMAL_EN
      if (e < -126) begin
        z = {s, 31'd0};
        lat = 9 + s1;
        return;
      end
`endif
      n2 = 0;
      sh = k - 23;
      if (e < -126) begin
        n2 = -126 - e;
        sh = sh + n2;
        e = -126;
      end
      lat = 11 + lza + lzb + s1 + n2;
      g = 1'b0;
      st = 1'b0;
      if (sh <= 0) begin
        mant = p << (-sh);
      end else if (sh >= 64) begin
        mant = 0;
        st = (p != 0);
      end else begin
        mant = p >> sh;
        g = p[sh-1];
        st = ((p & ((64'd1 << (sh - 1)) - 64'd1)) != 0);
      end
      if (g && (st || mant[0])) mant = mant + 64'd1;
      if (mant[24]) begin
        mant = mant >> 1;
        e++;
      end
      if (e > 127) z = {s, 8'hFF, 23'd0};
      else z = {s, mant[23] ? 8'(e + 127) : 8'd0, mant[22:0]};
    end
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0] ex;
    logic [22:0] fr;
    case ($urandom_range(0, 9))
      0: ex = 8'd0;
      1: ex = 8'hFF;
      2: ex = 8'($urandom_range(1, 24));
      3: ex = 8'($urandom_range(230, 254));
      default: ex = 8'($urandom_range(90, 164));
    endcase
    case ($urandom_range(0, 3))
      0: fr = 23'd0;
      1: fr = 23'($urandom_range(1, 255));
      default: fr = 23'($urandom);
    endcase
    return {1'($urandom), ex, fr};
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (o_AB_ACK !== 1'b1 && n < 50) begin
      @(posedge i_CLK);
      #1;
      n++;
    end
    checks++;
    if (o_AB_ACK !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: o_AB_ACK=%b required 1", tag, o_AB_ACK);
    end
  endtask

  // Called #1 after an edge with o_AB_ACK high; the next edge accepts.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input bit noisy,
                       output logic [31:0] z, output int lat);
    i_A = a;
    i_B = b;
    i_AB_STB = 1'b1;
    @(posedge i_CLK);
    #1;
    i_AB_STB = noisy;
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      if (noisy) begin
        i_A = $urandom;
        i_B = $urandom;
      end
      @(posedge i_CLK);
      #1;
      if (o_Z_STB === 1'b1) begin
        lat = n;
        break;
      end
    end
    i_AB_STB = 1'b0;
    z = o_Z;
  endtask

  task automatic test_reset();
    i_RST = 1'b1;
    i_AB_STB = 1'b0;
    i_Z_ACK = 1'b0;
    repeat (3) @(posedge i_CLK);
    #1;
    checks += 3;
    if (o_AB_ACK !== 1'b0) begin
      errors++;
      $display("FAIL rst_ack: got %b required 0", o_AB_ACK);
    end
    if (o_Z_STB !== 1'b0) begin
      errors++;
      $display("FAIL rst_stb: got %b required 0", o_Z_STB);
    end
    if (o_Z !== 32'd0) begin
      errors++;
      $display("FAIL rst_z: got %h required 0", o_Z);
    end
    i_RST = 1'b0;
    @(posedge i_CLK);
    #1;
    checks++;
    if (o_AB_ACK !== 1'b1) begin
      errors++;
      $display("FAIL rst_rel_ack: got %b required 1", o_AB_ACK);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic [31:0] vz [9];
    logic [31:0] z, mz;
    int lat, mlat;
    va = '{32'h4000_0000, 32'hBFC0_0000, 32'h7FC0_0000,
           32'h7F80_0000, 32'h7F00_0000, 32'h0080_0000,
           32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000};
    vb = '{32'h4040_0000, 32'h4000_0000, 32'h3F80_0000,
           32'h0000_0000, 32'h7F00_0000, 32'h3F00_0000,
           32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000};
    vz = '{32'h40C0_0000, 32'hC040_0000, 32'h7FC0_0000,
           32'h7FC0_0000, 32'h7F80_0000,
`ifdef FLOAT_MULTIPLIER_DENORMAL_EN
           32'h0040_0000,
`else
           32'h0000_0000,
`endif
           32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000};
    i_Z_ACK = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_ready("dir");
      do_op(va[i], vb[i], 1'b0, z, lat);
      model(va[i], vb[i], mz, mlat);
      checks += 2;
      if (z !== vz[i]) begin
        errors++;
        $display("FAIL dir_z %0d: %h*%h got %h required %h",
                 i, va[i], vb[i], z, vz[i]);
      end
      if (lat != mlat) begin
        errors++;
        $display("FAIL dir_lat %0d: got %0d required %0d", i, lat, mlat);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, z, mz;
    int lat, mlat;
    i_Z_ACK = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a = rnd_op();
      b = rnd_op();
      model(a, b, mz, mlat);
      wait_ready("rnd");
      do_op(a, b, 1'b0, z, lat);
      checks += 2;
      if (z !== mz) begin
        errors++;
        $display("FAIL rnd_z: %h*%h got %h required %h", a, b, z, mz);
      end
      if (lat != mlat) begin
        errors++;
        $display("FAIL rnd_lat: %h*%h got %0d required %0d",
                 a, b, lat, mlat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, z, mz;
    int lat, mlat;
    i_Z_ACK = 1'b1;
    wait_ready("b2b");
    for (int i = 0; i < 5; i++) begin
      a = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      model(a, b, mz, mlat);
      do_op(a, b, 1'b0, z, lat);
      checks += 2;
      if (z !== mz || lat != mlat) begin
        errors++;
        $display("FAIL b2b_res: %h*%h got %h/%0d required %h/%0d",
                 a, b, z, lat, mz, mlat);
      end
      @(posedge i_CLK);
      #1;
      if (o_Z_STB !== 1'b0 || o_AB_ACK !== 1'b1) begin
        errors++;
        $display("FAIL b2b_turn: stb=%b ack=%b required 0/1",
                 o_Z_STB, o_AB_ACK);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, z, mz;
    int lat, mlat;
    i_Z_ACK = 1'b0;
    wait_ready("bp");
    a = 32'h3FC0_0001;
    b = {1'b1, 8'($urandom_range(110, 140)), 23'($urandom)};
    model(a, b, mz, mlat);
    do_op(a, b, 1'b1, z, lat);
    checks += 2;
    if (z !== mz) begin
      errors++;
      $display("FAIL bp_z: got %h required %h", z, mz);
    end
    if (lat != mlat) begin
      errors++;
      $display("FAIL bp_lat: got %0d required %0d", lat, mlat);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge i_CLK);
      #1;
      checks++;
      if (o_Z !== mz || o_Z_STB !== 1'b1 || o_AB_ACK !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold %0d: z=%h stb=%b ack=%b required %h/1/0",
                 i, o_Z, o_Z_STB, o_AB_ACK, mz);
      end
    end
    i_Z_ACK = 1'b1;
    @(posedge i_CLK);
    #1;
    i_Z_ACK = 1'b0;
    checks++;
    if (o_Z_STB !== 1'b0 || o_AB_ACK !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: stb=%b ack=%b required 0/1",
               o_Z_STB, o_AB_ACK);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] z, mz;
    int lat, mlat;
    bit seen;
    i_Z_ACK = 1'b1;
    wait_ready("rm");
    i_A = 32'h4000_0000;
    i_B = 32'h4040_0000;
    i_AB_STB = 1'b1;
    @(posedge i_CLK);
    #1;
    i_AB_STB = 1'b0;
    repeat (4) @(posedge i_CLK);
    #1;
    i_RST = 1'b1;
    @(posedge i_CLK);
    #1;
    i_RST = 1'b0;
    checks++;
    if (o_AB_ACK !== 1'b0 || o_Z_STB !== 1'b0 || o_Z !== 32'd0) begin
      errors++;
      $display("FAIL rm_reset: ack=%b stb=%b z=%h required 0/0/0",
               o_AB_ACK, o_Z_STB, o_Z);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge i_CLK);
      #1;
      if (o_Z_STB !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rm_nostb: stb seen=1 required 0");
    end
    wait_ready("rm2");
    model(32'h3F80_0000, 32'h3F80_0000, mz, mlat);
    do_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, z, lat);
    checks += 2;
    if (z !== 32'h3F80_0000) begin
      errors++;
      $display("FAIL rm_z: got %h required 3f800000", z);
    end
    if (lat != mlat) begin
      errors++;
      $display("FAIL rm_lat: got %0d required %0d", lat, mlat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge i_CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
